// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption control path.
// Datapath op encoding and round sequencer state names live here.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_LOAD = 3'd1,
      OP_ARK  = 3'd2,
      OP_ISR  = 3'd3,
      OP_ISB  = 3'd4,
      OP_IMC  = 3'd5
   } aes_op_e;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      KEYEXP,
      ARK0,
      R_ISR,
      R_ISB,
      R_ARK,
      R_IMC,
      F_ISR,
      F_ISB,
      F_ARK,
      DONE
   } aes_seq_state_e;

   localparam int NR       = 10;
   localparam int IMC_COLS = 4;

endpackage

// File: rtl/aes_round_sequencer.sv
// Round sequencer for AES-128 decryption: turns a level start request
// into per-cycle datapath commands (load, op, round key, mix column).
module aes_round_sequencer
   import aes_ctrl_pkg::*;
#(
   parameter int KEYEXP_CYCLES = 10
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       AES_START,
   output logic       AES_DONE,
   output logic       BUSY,
   output logic       KEY_EXP_EN,
   output logic       STATE_LD,
   output logic [2:0] OP_SEL,
   output logic [3:0] ROUND_KEY_IDX,
   output logic [1:0] MIX_COL
);

   localparam logic [7:0] KEXP_LAST = 8'(KEYEXP_CYCLES - 1);
   localparam logic [7:0] COL_LAST  = 8'(IMC_COLS - 1);
   localparam logic [3:0] RND_FIRST = 4'(NR - 1);
   localparam logic [3:0] KEY_LAST  = 4'(NR);

   aes_seq_state_e state_q, state_d;
   logic [3:0]     rnd_q, rnd_d;
   logic [7:0]     cnt_q, cnt_d;
   aes_op_e        op;
   logic           busy;

   // State and counter registers; reset returns everything to idle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state sequencing plus Moore output decode of the current state.
   always_comb begin
      state_d       = state_q;
      rnd_d         = rnd_q;
      cnt_d         = cnt_q;
      op            = OP_NONE;
      busy          = 1'b1;
      AES_DONE      = 1'b0;
      KEY_EXP_EN    = 1'b0;
      STATE_LD      = 1'b0;
      ROUND_KEY_IDX = '0;
      MIX_COL       = '0;

      unique case (state_q)
         IDLE: begin
            busy  = 1'b0;
            rnd_d = '0;
            cnt_d = '0;
            if (AES_START) state_d = LOAD;
         end
         LOAD: begin
            op       = OP_LOAD;
            STATE_LD = 1'b1;
            cnt_d    = '0;
            state_d  = KEYEXP;
         end
         KEYEXP: begin
            KEY_EXP_EN = 1'b1;
            if (cnt_q == KEXP_LAST) begin
               cnt_d   = '0;
               state_d = ARK0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ARK0: begin
            op            = OP_ARK;
            STATE_LD      = 1'b1;
            ROUND_KEY_IDX = KEY_LAST;
            rnd_d         = RND_FIRST;
            state_d       = R_ISR;
         end
         R_ISR: begin
            op       = OP_ISR;
            STATE_LD = 1'b1;
            state_d  = R_ISB;
         end
         R_ISB: begin
            op       = OP_ISB;
            STATE_LD = 1'b1;
            state_d  = R_ARK;
         end
         R_ARK: begin
            op            = OP_ARK;
            STATE_LD      = 1'b1;
            ROUND_KEY_IDX = rnd_q;
            cnt_d         = '0;
            state_d       = R_IMC;
         end
         R_IMC: begin
            op       = OP_IMC;
            STATE_LD = 1'b1;
            MIX_COL  = cnt_q[1:0];
            if (cnt_q == COL_LAST) begin
               cnt_d = '0;
               if (rnd_q > 4'd1) begin
                  rnd_d   = rnd_q - 4'd1;
                  state_d = R_ISR;
               end else begin
                  state_d = F_ISR;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         F_ISR: begin
            op       = OP_ISR;
            STATE_LD = 1'b1;
            state_d  = F_ISB;
         end
         F_ISB: begin
            op       = OP_ISB;
            STATE_LD = 1'b1;
            state_d  = F_ARK;
         end
         F_ARK: begin
            op       = OP_ARK;
            STATE_LD = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            busy     = 1'b0;
            AES_DONE = 1'b1;
            if (!AES_START) state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Dropping start mid-run abandons the run and clears both counters.
      if (busy && !AES_START) begin
         state_d = IDLE;
         rnd_d   = '0;
         cnt_d   = '0;
      end

      BUSY   = busy;
      OP_SEL = op;
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: trace model of a whole run, compared
// every cycle for two instances (key expansion of 10 and of 1 cycle).
module tb_aes_round_sequencer;

   localparam int NONE = 0;
   localparam int LD   = 1;
   localparam int ARK  = 2;
   localparam int ISR  = 3;
   localparam int ISB  = 4;
   localparam int IMC  = 5;

   typedef struct packed {
      logic       done;
      logic       busy;
      logic       kexp;
      logic       ld;
      logic [2:0] op;
      logic [3:0] idx;
      logic [1:0] col;
   } out_t;

   logic       clk;
   logic [1:0] rst;
   logic [1:0] start;

   logic       done0, busy0, kexp0, ld0;
   logic [2:0] op0;
   logic [3:0] idx0;
   logic [1:0] col0;
   logic       done1, busy1, kexp1, ld1;
   logic [2:0] op1;
   logic [3:0] idx1;
   logic [1:0] col1;

   out_t act [2];
   assign act[0] = {done0, busy0, kexp0, ld0, op0, idx0, col0};
   assign act[1] = {done1, busy1, kexp1, ld1, op1, idx1, col1};

   aes_round_sequencer #(.KEYEXP_CYCLES(10)) dut0 (
      .CLK(clk), .RESET(rst[0]), .AES_START(start[0]),
      .AES_DONE(done0), .BUSY(busy0), .KEY_EXP_EN(kexp0),
      .STATE_LD(ld0), .OP_SEL(op0), .ROUND_KEY_IDX(idx0),
      .MIX_COL(col0)
   );

   aes_round_sequencer #(.KEYEXP_CYCLES(1)) dut1 (
      .CLK(clk), .RESET(rst[1]), .AES_START(start[1]),
      .AES_DONE(done1), .BUSY(busy1), .KEY_EXP_EN(kexp1),
      .STATE_LD(ld1), .OP_SEL(op1), .ROUND_KEY_IDX(idx1),
      .MIX_COL(col1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   out_t trace [2][128];
   int   tlen [2];
   int   mpos [2];
   int   n_assert;
   int   n_fail;
   bit   chk_en;

   function automatic out_t mk(bit d, bit b, bit k, bit l,
                               int op, int idx, int col);
      out_t o;
      o.done = d;
      o.busy = b;
      o.kexp = k;
      o.ld   = l;
      o.op   = 3'(op);
      o.idx  = 4'(idx);
      o.col  = 2'(col);
      return o;
   endfunction

   function automatic void push(int i, out_t o);
      trace[i][tlen[i]] = o;
      tlen[i]++;
   endfunction

   // Expected command stream of one complete run, from LOAD to DONE.
   function automatic void build(int i, int k);
      tlen[i] = 0;
      push(i, mk(0, 1, 0, 1, LD, 0, 0));
      for (int c = 0; c < k; c++) push(i, mk(0, 1, 1, 0, NONE, 0, 0));
      push(i, mk(0, 1, 0, 1, ARK, 10, 0));
      for (int r = 9; r >= 1; r--) begin
         push(i, mk(0, 1, 0, 1, ISR, 0, 0));
         push(i, mk(0, 1, 0, 1, ISB, 0, 0));
         push(i, mk(0, 1, 0, 1, ARK, r, 0));
         for (int c = 0; c < 4; c++) push(i, mk(0, 1, 0, 1, IMC, 0, c));
      end
      push(i, mk(0, 1, 0, 1, ISR, 0, 0));
      push(i, mk(0, 1, 0, 1, ISB, 0, 0));
      push(i, mk(0, 1, 0, 1, ARK, 0, 0));
      push(i, mk(1, 0, 0, 0, NONE, 0, 0));
   endfunction

   function automatic out_t expv(int i);
      if (mpos[i] < 0) return '0;
      return trace[i][mpos[i]];
   endfunction

   task automatic check(string name, logic [31:0] a, logic [31:0] e);
      n_assert++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   // One clock: advance the model on the edge, compare on the falling edge.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) mpos[i] = -1;
         else if (mpos[i] < 0) begin
            if (start[i]) mpos[i] = 0;
         end else if (!start[i]) mpos[i] = -1;
         else if (mpos[i] < tlen[i] - 1) mpos[i]++;
      end
      @(negedge clk);
      if (chk_en)
         for (int i = 0; i < 2; i++)
            check($sformatf("trace%0d_pos%0d", i, mpos[i]),
                  32'(act[i]), 32'(expv(i)));
   endtask

   task automatic run(int i, int lat, int lds, int kxs);
      int n, ld_n, kx_n;
      n = 0;
      ld_n = 0;
      kx_n = 0;
      start[i] = 1'b1;
      do begin
         tick();
         n++;
         ld_n += int'(act[i].ld);
         kx_n += int'(act[i].kexp);
      end while (!act[i].done && n < 300);
      check($sformatf("latency%0d", i), 32'(n), 32'(lat));
      check($sformatf("ld_count%0d", i), 32'(ld_n), 32'(lds));
      check($sformatf("kexp_count%0d", i), 32'(kx_n), 32'(kxs));
   endtask

   initial begin
      int  n;
      bit  seen;
      n_assert = 0;
      n_fail   = 0;
      chk_en   = 1'b0;
      mpos[0]  = -1;
      mpos[1]  = -1;
      build(0, 10);
      build(1, 1);
      rst   = 2'b11;
      start = 2'b00;
      tick();
      chk_en = 1'b1;
      tick();
      check("reset_outs", 32'(act[0]), 32'd0);
      rst = 2'b00;
      tick();

      run(0, 79, 68, 10);

      repeat (20) tick();
      check("hold_done", 32'(act[0].done), 32'd1);
      start[0] = 1'b0;
      tick();
      check("release_done", 32'(act[0].done), 32'd0);
      start[0] = 1'b1;
      tick();
      check("restart_load", 32'(act[0].op), 32'(LD));

      n = 0;
      seen = 1'b0;
      while (n < 200 && !(seen && act[0].op == 3'(IMC) && act[0].col == 2'd2)) begin
         tick();
         n++;
         if (act[0].op == 3'(ARK) && act[0].idx == 4'd5) seen = 1'b1;
      end
      check("abort_pos", 32'(n), 32'd45);
      start[0] = 1'b0;
      tick();
      check("abort_busy", 32'(act[0].busy), 32'd0);
      check("abort_op", 32'(act[0].op), 32'(NONE));
      run(0, 79, 68, 10);

      start[0] = 1'b0;
      tick();
      start[0] = 1'b1;
      repeat (3) tick();
      check("in_keyexp", 32'(act[0].kexp), 32'd1);
      rst[0] = 1'b1;
      tick();
      check("midrun_reset", 32'(act[0]), 32'd0);
      rst[0] = 1'b0;
      tick();
      check("post_reset_load", 32'(act[0].op), 32'(LD));
      start[0] = 1'b0;
      tick();

      run(1, 70, 68, 1);
      start[1] = 1'b0;
      tick();
      rst[1]   = 1'b1;
      start[1] = 1'b1;
      tick();
      tick();
      check("rst_start_idle", 32'(act[1]), 32'd0);
      rst[1] = 1'b0;
      tick();
      check("rst_release_load", 32'(act[1].op), 32'(LD));
      start[1] = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM for the AES-128 decryption datapath behind the Avalon AES slave.
- Takes the start bit and produces per-cycle datapath commands: state-register load, operation select, round-key index and InvMixColumns column select.
- Runs key-expansion wait, the initial AddRoundKey, 9 full inverse rounds and the final round, then raises done.
- Sits between the start/done registers and the AES datapath. The datapath holds no sequencing logic.

Parameters:
- KEYEXP_CYCLES, 10, cycles spent in key expansion (KEY_EXP_EN high); legal range 1..255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RESET  in  1  reset, synchronous and active-high
- AES_START  in  1  level start request from the start register
- AES_DONE  out  1  decryption complete; held until AES_START falls
- BUSY  out  1  high in every state except IDLE and DONE
- KEY_EXP_EN  out  1  key-expansion unit enable
- STATE_LD  out  1  load the 128-bit state register this cycle
- OP_SEL  out  3  datapath op, aes_op_e: NONE=0, LOAD=1, ARK=2, ISR=3, ISB=4, IMC=5
- ROUND_KEY_IDX  out  4  round key index 0..10 used by ARK
- MIX_COL  out  2  column 0..3 processed by IMC

Behaviour:
- All outputs are Moore, decoded from registered state and counters only. There is no combinational path from AES_START to any output.
- Reset (RESET=1 at an edge) forces, regardless of current state:
  - state IDLE
  - AES_DONE=0, BUSY=0, KEY_EXP_EN=0, STATE_LD=0
  - OP_SEL=NONE, ROUND_KEY_IDX=0, MIX_COL=0
  - round counter 0, cycle counter 0
- States and per-state outputs:
  - IDLE: OP_SEL=NONE. On AES_START=1 go to LOAD.
  - LOAD, 1 cycle: OP_SEL=LOAD, STATE_LD=1. Ciphertext is copied into the state register.
  - KEYEXP, KEYEXP_CYCLES cycles: KEY_EXP_EN=1, STATE_LD=0. An 8-bit counter runs up to KEYEXP_CYCLES-1.
  - ARK0, 1 cycle: OP_SEL=ARK, ROUND_KEY_IDX=10, STATE_LD=1. Round counter r is loaded with 9.
  - Full rounds, repeated for r=9 down to 1:
    - R_ISR: OP_SEL=ISR
    - R_ISB: OP_SEL=ISB
    - R_ARK: OP_SEL=ARK, ROUND_KEY_IDX=r
    - R_IMC: OP_SEL=IMC, MIX_COL=0,1,2,3 over 4 consecutive cycles
    - Each round is 7 cycles with STATE_LD=1 in every cycle.
    - After IMC column 3: if r>1, decrement r and go to R_ISR; else go to F_ISR.
  - Final round: F_ISR, then F_ISB, then F_ARK (ROUND_KEY_IDX=0). STATE_LD=1 in all three.
  - DONE: AES_DONE=1, BUSY=0, STATE_LD=0, OP_SEL=NONE. Stay while AES_START=1; go to IDLE the edge after AES_START=0.
- ROUND_KEY_IDX is 0 in every non-ARK state. MIX_COL is 0 in every non-IMC state.
- Latency: AES_DONE first high after the (KEYEXP_CYCLES+69)th rising edge following the edge that samples AES_START=1 in IDLE. This is 79 for the default.
- Abort: AES_START=0 sampled in any BUSY state sends the FSM to IDLE at that edge. AES_DONE never asserts for that run, and both counters clear.
- Restart: AES_START held high in DONE does not restart. A new run needs AES_START low (IDLE) then high again.
- Simultaneous RESET and AES_START: reset wins.
- STATE_LD=1 cycle count per completed run: exactly 1 + 1 + 63 + 3 = 68.

Decomposition:
- Package aes_ctrl_pkg holds:
  - aes_op_e (3-bit enum above)
  - aes_seq_state_e: IDLE, LOAD, KEYEXP, ARK0, R_ISR, R_ISB, R_ARK, R_IMC, F_ISR, F_ISB, F_ARK, DONE
  - constants NR=10 and IMC_COLS=4
- No sub-module: one FSM plus a round counter (4 bits) and a cycle counter (8 bits, shared by KEYEXP and IMC column count).

Test Plan:
- Normal run, KEYEXP_CYCLES=10: START=1 held -> AES_DONE rises after edge 79. Trace must be LOAD, 10 cycles of KEY_EXP_EN, ARK idx10, then ISR, ISB, ARK idx9, IMC cols 0..3, ... ARK idx1 round, then ISR, ISB, ARK idx0. STATE_LD count = 68.
- Done hold and release: keep START=1 for 20 cycles after done -> AES_DONE stays 1 with no new LOAD. Drop START -> IDLE and AES_DONE=0 next edge. Raise START -> LOAD one edge later.
- Abort: drop START during R_IMC col 2 of round 5 -> IDLE at that edge, BUSY=0, AES_DONE never 1. Immediate restart completes in the full 79 cycles.
- Reset mid-run: RESET=1 for one edge during KEYEXP -> all outputs at reset values the next cycle. START still high -> LOAD on the following edge.
- Parameter corner, KEYEXP_CYCLES=1: exactly one KEY_EXP_EN cycle; AES_DONE after edge 70.
- RESET and START both high in IDLE -> stays IDLE. RESET released with START high -> LOAD next edge.
